mem_stage: RTL and testbench

- Pipeline memory-access stage between EXE and WB.
- Accepts one EXE→MEM record per handshake. Drives the synchronous data RAM (1-cycle read latency, byte write enables).
- Aligns and extends load data, and detects address-error exceptions (AdEL/AdES).
- Presents a registered MEM→WB record under valid/ready back-pressure.

---
 rtl/mem_pkg.sv | 33 +++
 rtl/mem_align.sv | 65 ++++++
 rtl/mem_stage.sv | 118 +++++++++++
 tb/tb_mem_stage.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the EXE->MEM->WB memory stage.
//   - memory op encodings carried on in_op
//   - is_load / is_store classification helpers
//   - stage FSM state encoding
package mem_pkg;

  typedef enum logic [3:0] {
    MOP_NONE = 4'd0,
    MOP_LB   = 4'd1,
    MOP_LBU  = 4'd2,
    MOP_LH   = 4'd3,
    MOP_LHU  = 4'd4,
    MOP_LW   = 4'd5,
    MOP_SB   = 4'd6,
    MOP_SH   = 4'd7,
    MOP_SW   = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // output slot empty
    ST_WAIT = 2'd1,  // load issued, RAM data returns this cycle
    ST_FULL = 2'd2   // output record held
  } mem_state_e;

  function automatic logic is_load(input logic [3:0] op);
    return op inside {MOP_LB, MOP_LBU, MOP_LH, MOP_LHU, MOP_LW};
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return op inside {MOP_SB, MOP_SH, MOP_SW};
  endfunction

endpackage

// File: rtl/mem_align.sv
// mem_align: combinational lane handling for the memory stage.
//   acc_op/acc_off/acc_wdata : op, addr[1:0] and store data of the record being accepted
//   st_we/st_wdata           : raw byte-enable mask and lane-replicated store data
//   misal                    : alignment fault for the accepted op
//   ld_op/ld_off/ld_word     : registered load op, addr[1:0] and RAM word
//   ld_data                  : lane-selected, extended load result
module mem_align
  import mem_pkg::*;
(
  input  logic [3:0]  acc_op,
  input  logic [1:0]  acc_off,
  input  logic [31:0] acc_wdata,
  output logic [3:0]  st_we,
  output logic [31:0] st_wdata,
  output logic        misal,
  input  logic [3:0]  ld_op,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_b;
  logic [15:0] ld_h;

  // Store mask is raw here; the top gates it with accept and ~misal.
  always_comb begin
    st_we    = 4'b0000;
    st_wdata = acc_wdata;
    misal    = 1'b0;
    case (acc_op)
      MOP_LH, MOP_LHU: misal = acc_off[0];
      MOP_LW:          misal = |acc_off;
      MOP_SB: begin
        st_we    = 4'b0001 << acc_off;
        st_wdata = {4{acc_wdata[7:0]}};
      end
      MOP_SH: begin
        misal    = acc_off[0];
        st_we    = 4'b0011 << acc_off;
        st_wdata = {2{acc_wdata[15:0]}};
      end
      MOP_SW: begin
        misal    = |acc_off;
        st_we    = 4'b1111;
      end
      default: ;
    endcase
  end

  // Halfword loads are known aligned, so only off[1] picks the half.
  assign ld_b = ld_word[{ld_off, 3'b000} +: 8];
  assign ld_h = ld_off[1] ? ld_word[31:16] : ld_word[15:0];

  always_comb begin
    ld_data = ld_word;
    case (ld_op)
      MOP_LB:  ld_data = {{24{ld_b[7]}}, ld_b};
      MOP_LBU: ld_data = {24'h0, ld_b};
      MOP_LH:  ld_data = {{16{ld_h[15]}}, ld_h};
      MOP_LHU: ld_data = {16'h0, ld_h};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: pipeline memory-access stage between EXE and WB.
//   clk, reset (async, active low), flush (sync)
//   in_*      : EXE->MEM record, valid/ready handshake
//   out_*     : registered MEM->WB record, valid/ready handshake
//   adel/ades : load/store address error with the record, bva = faulting address
//   ram_*     : synchronous data RAM, one-cycle read latency, byte write enables
module mem_stage
  import mem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [31:0]       in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [4:0]        in_rd,
  input  logic              in_wb_en,
  input  logic [31:0]       in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_wdata,
  output logic [4:0]        out_rd,
  output logic              out_wb_en,
  output logic [31:0]       out_pc,
  output logic              adel,
  output logic              ades,
  output logic [31:0]       bva,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [3:0]        ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  mem_state_e  state, state_nxt;
  logic [3:0]  lat_op;
  logic [1:0]  lat_off;
  logic [3:0]  st_we;
  logic [31:0] ld_data;
  logic        misal, accept, ld, st, ld_go;

  mem_align u_align (
    .acc_op    (in_op),
    .acc_off   (in_addr[1:0]),
    .acc_wdata (in_wdata),
    .st_we     (st_we),
    .st_wdata  (ram_wdata),
    .misal     (misal),
    .ld_op     (lat_op),
    .ld_off    (lat_off),
    .ld_word   (ram_rdata),
    .ld_data   (ld_data)
  );

  assign ld       = is_load(in_op);
  assign st       = is_store(in_op);
  assign in_ready = (state == ST_IDLE) | ((state == ST_FULL) & out_ready);
  assign accept   = in_valid & in_ready & ~flush;
  assign ld_go    = accept & ld & ~misal;   // aligned load: RAM read in flight
  assign ram_addr = in_addr[ADDR_W+1:2];
  assign ram_we   = (accept & st & ~misal) ? st_we : 4'b0000;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush)                               state_nxt = ST_IDLE;
    else if (accept)                         state_nxt = ld_go ? ST_WAIT : ST_FULL;
    else if (state == ST_WAIT)               state_nxt = ST_FULL;
    else if (state == ST_FULL && out_ready)  state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_wdata <= '0;
      out_rd    <= '0;
      out_wb_en <= 1'b0;
      out_pc    <= '0;
      adel      <= 1'b0;
      ades      <= 1'b0;
      bva       <= '0;
      lat_op    <= '0;
      lat_off   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      adel      <= 1'b0;
      ades      <= 1'b0;
    end else if (accept) begin
      // Loads become visible only after the WAIT cycle latches RAM data.
      out_valid <= ~ld_go;
      out_wdata <= in_addr;
      out_rd    <= in_rd;
      out_wb_en <= in_wb_en & ~st & ~misal;
      out_pc    <= in_pc;
      adel      <= ld & misal;
      ades      <= st & misal;
      if (misal) bva <= in_addr;
      lat_op    <= in_op;
      lat_off   <= in_addr[1:0];
    end else if (state == ST_WAIT) begin
      out_valid <= 1'b1;
      out_wdata <= ld_data;
    end else if (state == ST_FULL && out_ready) begin
      out_valid <= 1'b0;
      adel      <= 1'b0;
      ades      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
  import mem_pkg::*;

  localparam int ADDR_W = 8;

  logic        clk = 1'b0, reset = 1'b0, flush = 1'b0;
  logic        in_valid = 1'b0, in_wb_en = 1'b0, out_ready = 1'b0;
  logic [3:0]  in_op = '0;
  logic [31:0] in_addr = '0, in_wdata = '0, in_pc = '0;
  logic [4:0]  in_rd = '0;
  logic        in_ready, out_valid, out_wb_en, adel, ades;
  logic [31:0] out_wdata, out_pc, bva, ram_wdata;
  logic [31:0] ram_rdata = '0;
  logic [4:0]  out_rd;
  logic [ADDR_W-1:0] ram_addr;
  logic [3:0]  ram_we;

  always #5 clk = ~clk;

  mem_stage #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_addr(in_addr),
    .in_wdata(in_wdata), .in_rd(in_rd), .in_wb_en(in_wb_en), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_wdata(out_wdata), .out_rd(out_rd),
    .out_wb_en(out_wb_en), .out_pc(out_pc), .adel(adel), .ades(ades), .bva(bva),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Environment RAM: synchronous, 1-cycle read, byte write enables.
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (ram_we[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
    ram_rdata <= mem[ram_addr];
  end

  // Reference model: expected memory image plus the one-slot record view.
  typedef struct {
    logic [31:0] wdata;
    bit          chk_wdata;
    logic [4:0]  rd;
    logic        wb;
    logic [31:0] pc;
    logic        adel, ades;
    logic [31:0] bva;
  } rec_t;

  logic [31:0] refmem [0:255];
  bit   m_valid = 0, m_wait = 0, m_clr = 1;
  rec_t m_rec;
  int   errs = 0, nchk = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [3:0] op, input int a, input logic [31:0] word);
    logic [31:0] b, h;
    b = (word >> (8*a)) & 32'hFF;
    h = (word >> (8*a)) & 32'hFFFF;
    case (op)
      MOP_LB:  return (b >= 128)   ? b + 32'hFFFF_FF00 : b;
      MOP_LBU: return b;
      MOP_LH:  return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      MOP_LHU: return h;
      default: return word;
    endcase
  endfunction

  // One clock: drive inputs, check at negedge against the model, advance the model.
  task automatic step(input logic v, input logic [3:0] op, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [4:0] rd, input logic wb,
                      input logic [31:0] pc, input logic ordy, input logic fl);
    bit ld, st, mis, rdy, acc;
    int a, w;
    logic [3:0]  we;
    logic [31:0] wdat;
    in_valid = v; in_op = op; in_addr = addr; in_wdata = wd; in_rd = rd;
    in_wb_en = wb; in_pc = pc; out_ready = ordy; flush = fl;
    @(negedge clk);
    ld  = (op >= 1) && (op <= 5);
    st  = (op >= 6) && (op <= 8);
    a   = int'(addr % 4);
    w   = int'((addr / 4) % 256);
    mis = ((op == MOP_LH || op == MOP_LHU || op == MOP_SH) && (addr % 2 != 0)) ||
          ((op == MOP_LW || op == MOP_SW) && (addr % 4 != 0));
    rdy = !m_wait && (!m_valid || ordy);
    acc = v && rdy && !fl;
    we = 4'b0000; wdat = '0;
    if (acc && st && !mis) begin
      case (op)
        MOP_SB:  begin we = 4'(1 << a); wdat = (wd & 32'hFF)   * 32'h0101_0101; end
        MOP_SH:  begin we = 4'(3 << a); wdat = (wd & 32'hFFFF) * 32'h0001_0001; end
        default: begin we = 4'hF;       wdat = wd; end
      endcase
    end
    chk("in_ready", {31'b0, in_ready}, {31'b0, rdy});
    chk("ram_we", {28'b0, ram_we}, {28'b0, we});
    if (acc && (ld || st) && !mis) chk("ram_addr", {24'b0, ram_addr}, 32'(w));
    if (we != 0) chk("ram_wdata", ram_wdata, wdat);
    chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
    if (m_valid) begin
      if (m_rec.chk_wdata) chk("out_wdata", out_wdata, m_rec.wdata);
      chk("out_rd", {27'b0, out_rd}, {27'b0, m_rec.rd});
      chk("out_wb_en", {31'b0, out_wb_en}, {31'b0, m_rec.wb});
      chk("out_pc", out_pc, m_rec.pc);
      chk("adel", {31'b0, adel}, {31'b0, m_rec.adel});
      chk("ades", {31'b0, ades}, {31'b0, m_rec.ades});
      if (m_rec.adel || m_rec.ades) chk("bva", bva, m_rec.bva);
    end else if (m_clr) begin
      chk("exc_clear", {30'b0, adel, ades}, 32'h0);
    end
    if (fl) begin
      m_valid = 0; m_wait = 0; m_clr = 1;
    end else if (acc) begin
      m_rec.rd        = rd;
      m_rec.pc        = pc;
      m_rec.adel      = ld && mis;
      m_rec.ades      = st && mis;
      m_rec.bva       = addr;
      m_rec.wb        = wb && !st && !mis;
      m_rec.chk_wdata = !st && !mis;
      m_rec.wdata     = ld ? ref_load(op, a, refmem[w]) : addr;
      for (int i = 0; i < 4; i++)
        if (we[i]) refmem[w][8*i +: 8] = wdat[8*i +: 8];
      m_wait  = ld && !mis;
      m_valid = !m_wait;
      m_clr   = 0;
    end else if (m_wait) begin
      m_wait = 0; m_valid = 1;
    end else if (m_valid && ordy) begin
      m_valid = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) step(0, MOP_NONE, 0, 0, 0, 0, 0, ordy, 0);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_out_wdata", out_wdata, 0);
    chk("rst_out_rd", {27'b0, out_rd}, 0);
    chk("rst_out_wb_en", {31'b0, out_wb_en}, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_adel", {31'b0, adel}, 0);
    chk("rst_ades", {31'b0, ades}, 0);
    chk("rst_bva", bva, 0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Give every word the model may read a defined value.
    for (int i = 0; i < 16; i++) step(1, MOP_SW, 32'(4*i), $urandom, 0, 0, 0, 1, 0);
    idle(1, 1);

    // LW round trip, then lane select / extension
    step(1, MOP_SW, 32'h10, 32'hDEAD_BEEF, 0, 0, 32'h8, 1, 0);
    step(1, MOP_LW, 32'h10, 0, 5, 1, 32'hC, 1, 0);
    idle(3, 1);
    step(1, MOP_SW, 32'h10, 32'h80FF_1234, 0, 0, 0, 1, 0);
    step(1, MOP_LB,  32'h13, 0, 1, 1, 32'h20, 1, 0); idle(2, 1);
    step(1, MOP_LBU, 32'h13, 0, 2, 1, 32'h24, 1, 0); idle(2, 1);
    step(1, MOP_LH,  32'h12, 0, 3, 1, 32'h28, 1, 0); idle(2, 1);
    step(1, MOP_LHU, 32'h12, 0, 4, 1, 32'h2C, 1, 0); idle(2, 1);

    // SH lanes, then address errors
    step(1, MOP_SH, 32'h22, 32'h0000_ABCD, 0, 0, 32'h30, 1, 0);
    step(1, MOP_LW, 32'h20, 0, 6, 1, 32'h34, 1, 0); idle(2, 1);
    step(1, MOP_LW, 32'h11, 0, 7, 1, 32'h40, 1, 0);
    step(1, MOP_SW, 32'h02, 32'h5555_AAAA, 0, 0, 32'h44, 1, 0);
    step(1, MOP_LH, 32'h0F, 0, 8, 1, 32'h48, 1, 0);
    idle(1, 1);

    // Back-pressure hold, then same-cycle drain + accept
    step(1, MOP_SW, 32'h30, 32'h1111_2222, 0, 0, 32'h50, 0, 0);
    for (int i = 0; i < 3; i++) step(1, MOP_NONE, 32'h1234, 0, 9, 1, 32'h54, 0, 0);
    step(1, MOP_NONE, 32'h1234, 0, 9, 1, 32'h54, 1, 0);
    idle(2, 1);

    // Async reset while a load is in WAIT
    step(1, MOP_LW, 32'h14, 0, 7, 1, 32'h100, 1, 0);
    #2 reset = 1'b0;
    #1;
    chk("rstw_out_valid", {31'b0, out_valid}, 0);
    chk("rstw_out_rd", {27'b0, out_rd}, 0);
    chk("rstw_out_wb_en", {31'b0, out_wb_en}, 0);
    chk("rstw_out_pc", out_pc, 0);
    m_valid = 0; m_wait = 0; m_clr = 1;
    @(posedge clk); #1;
    reset = 1'b1;
    idle(1, 1);

    // Flush blocks an SW and empties a held slot
    step(1, MOP_NONE, 32'h77, 0, 3, 1, 32'h60, 0, 0);
    step(1, MOP_SW, 32'h18, 32'hCAFE_F00D, 0, 0, 32'h64, 1, 1);
    idle(1, 1);
    step(1, MOP_LW, 32'h18, 0, 4, 1, 32'h68, 1, 0);
    step(0, MOP_NONE, 0, 0, 0, 0, 0, 1, 1);
    idle(2, 1);

    // Random traffic; upper address bits above the RAM index are noise.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] ad;
      ad = ($urandom_range(0, 63)) | ($urandom << 10);
      step(($urandom % 4) != 0, 4'($urandom_range(0, 8)), ad, $urandom,
           5'($urandom), 1'($urandom), $urandom, ($urandom % 4) != 0, ($urandom % 20) == 0);
    end
    idle(3, 1);

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
